multicycle_ctrl: RTL
====================

# multicycle_ctrl

Main sequencing controller for the multicycle ARM-subset core. It decodes the instruction register fields and steps the shared datapath (one memory, one ALU) through fetch, decode, execute, memory and writeback states. It drives every datapath mux select and write strobe. Architectural writes are gated by the condition-check result `CondEx` supplied by the condition logic.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; the block is in reset while `reset`=0.
- `Op`  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- `Funct`  in  6  instruction bits [25:20]: [5]=I (immediate), [4:1]=cmd, [0]=S for DP or L for memory.
- `Rd`  in  4  destination register.
- `CondEx`  in  1  condition passes; valid from DECODE onward.
- `mem_ready`  in  1  memory handshake; present only with `MULTICYCLE_MEM_WAIT_EN`.
- `PCWrite`  out  1  PC register enable.
- `AdrSrc`  out  1  memory address select: 0=PC, 1=ALUOut.
- `IRWrite`  out  1  instruction register enable.
- `RegWrite`  out  1  register file write, gated by `CondEx`.
- `MemWrite`  out  1  memory write, gated by `CondEx`.
- `ALUSrcA`  out  2  00=Rn, 01=PC, 10=ALUOut.
- `ALUSrcB`  out  2  00=Rm, 01=ExtImm, 10=const 4.
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- `ALUControl`  out  2  00 add, 01 sub, 10 and, 11 orr.
- `FlagW`  out  2  [1]=N/Z write, [0]=C/V write; gated by `CondEx`.
- `state`  out  4  current state encoding, for debug.

## Operation
- Moore FSM. States use encodings 0–9: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. Encodings 10–15 are illegal and go to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 with Funct[5]=0→EXECR; Op=00 with Funct[5]=1→EXECI; Op=10→BRANCH; Op=11→FETCH with no strobes.
  - MEMADR: Funct[0]=1→MEMRD, else →MEMWR.
  - MEMRD→MEMWB.
  - EXECR/EXECI→ALUWB, except cmd=1010 (CMP)→FETCH with no writeback.
  - MEMWB, MEMWR, ALUWB and BRANCH→FETCH.
- Per-state outputs (unlisted strobes are 0; unlisted selects are don't-care, driven 0):
  - FETCH: AdrSrc=0, IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ALUControl=add, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ALUControl=add, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=add.
  - MEMRD: AdrSrc=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - EXECR: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ALUControl=add, ResultSrc=10, Branch=1.
- ALU decode, applied when ALUOp=1:
  - cmd 0100→add, 0010→sub, 1010→sub, 0000→and, 1100→orr; any other cmd→add with FlagW=00.
  - FlagW[1]=S, except CMP forces FlagW[1]=1.
  - FlagW[0]=FlagW[1] & (add|sub).
- Gating:
  - RegWrite=RegW&CondEx.
  - MemWrite=MemW&CondEx.
  - FlagW is FlagW_raw masked by CondEx.
  - PCWrite=NextPC | (Branch&CondEx) | (RegW&CondEx&(Rd==15)).
- While `reset`=0: state=FETCH, and PCWrite, IRWrite, RegWrite, MemWrite and FlagW are forced to 0. Reset asserted mid-instruction abandons it with no further strobes.

## Timing
- Latency from FETCH entry to next FETCH entry: BRANCH 3, CMP 3, DP 4, STR 4, LDR 5, undefined 2 cycles.
- Outputs are combinational from `state` only (plus `CondEx`/`Rd` gating); no input-to-output path bypasses the state register except the gating.
- The first FETCH strobes assert on the first clk edge after `reset` deasserts; they are visible in the cycle after release.

## Configuration
- `MULTICYCLE_MEM_WAIT_EN` defined: `mem_ready` port exists.
  - FETCH, MEMRD and MEMWR hold while `mem_ready`=0.
  - IRWrite, NextPC and MemWrite assert only in the cycle with `mem_ready`=1.
  - MEMWB is entered only after a ready MEMRD.
  - `mem_ready` held 0 stalls indefinitely with no strobes.
- Undefined: no `mem_ready` port; every state lasts one cycle.

## Structure
- Package `multicycle_ctrl_pkg` holds:
  - state enum (4-bit);
  - Op codes;
  - cmd codes (ADD, SUB, AND, ORR, CMP);
  - ALUControl, ALUSrcA/B and ResultSrc encodings.
- Sub-module `alu_dec`: combinational decode (ALUOp, Funct) → ALUControl, FlagW_raw.

## Test plan
- Reset low for 3 cycles, release with Op=00, Funct=001000 (ADD reg), CondEx=1, Rd=3 → state sequence 0,1,6,8,0; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
- LDR (Op=01, Funct[0]=1), CondEx=1 → states 0,1,2,3,4,0; ResultSrc=01 in MEMWB; AdrSrc=1 in MEMRD. Repeat with CondEx=0 → RegWrite stays 0.
- CMP imm with S=1 (Funct=110101), CondEx=1 → EXECI then FETCH; ALUControl=01, FlagW=11, RegWrite never 1.
- Branch (Op=10) with CondEx=0 → PCWrite=0 in BRANCH; CondEx=1 → PCWrite=1. ADD with Rd=15 → PCWrite=1 in ALUWB.
- With `MULTICYCLE_MEM_WAIT_EN`: STR with `mem_ready`=0 for 4 cycles in MEMWR → MemWrite=0 throughout, then exactly 1 cycle of MemWrite on ready. Reset pulsed mid-MEMRD → state=0 and all strobes 0 immediately.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset sequencing controller:
// FSM states, instruction field codes and datapath select encodings.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCA_RN     = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // CMP only updates flags, so it skips the ALU writeback state.
  function automatic logic is_cmp(input logic [3:0] cmd);
    return (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle. MULTICYCLE_MEM_WAIT_EN adds the mem_ready
// handshake from the shared memory.
interface multicycle_ctrl_if;

  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       CondEx;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic       mem_ready;
`endif

  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;
  logic [1:0] FlagW;
  logic [3:0] state;

`ifdef MULTICYCLE_MEM_WAIT_EN
  modport master (
    input  Op, Funct, Rd, CondEx, mem_ready,
    output PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite,
    output ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW, state
  );

  modport slave (
    output Op, Funct, Rd, CondEx, mem_ready,
    input  PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite,
    input  ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW, state
  );
`else
  modport master (
    input  Op, Funct, Rd, CondEx,
    output PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite,
    output ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW, state
  );

  modport slave (
    output Op, Funct, Rd, CondEx,
    input  PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite,
    input  ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW, state
  );
`endif

endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU decoder: maps the data-processing cmd and S bit to an ALU operation
// and the raw (ungated) flag write enables.
module alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic       i_alu_op,
  input  logic [4:0] i_funct,
  output logic [1:0] o_alu_control,
  output logic [1:0] o_flag_w_raw
);

  logic [3:0] w_cmd;
  logic       w_s;

  assign w_cmd = i_funct[4:1];
  assign w_s   = i_funct[0];

  // Command decode; unknown commands fall back to add with no flag update.
  always_comb begin
    o_alu_control = ALU_ADD;
    o_flag_w_raw  = 2'b00;
    if (i_alu_op) begin
      case (w_cmd)
        CMD_ADD: begin
          o_alu_control = ALU_ADD;
          o_flag_w_raw  = {w_s, w_s};
        end
        CMD_SUB: begin
          o_alu_control = ALU_SUB;
          o_flag_w_raw  = {w_s, w_s};
        end
        CMD_CMP: begin
          o_alu_control = ALU_SUB;
          o_flag_w_raw  = 2'b11;
        end
        CMD_AND: begin
          o_alu_control = ALU_AND;
          o_flag_w_raw  = {w_s, 1'b0};
        end
        CMD_ORR: begin
          o_alu_control = ALU_ORR;
          o_flag_w_raw  = {w_s, 1'b0};
        end
        default: begin
          o_alu_control = ALU_ADD;
          o_flag_w_raw  = 2'b00;
        end
      endcase
    end else begin
      o_alu_control = ALU_ADD;
      o_flag_w_raw  = 2'b00;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencing FSM for the multicycle core. Defining MULTICYCLE_MEM_WAIT_EN
// makes FETCH/MEMRD/MEMWR wait on mem_ready.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  multicycle_ctrl_if.master      bus
);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_run;
  logic       w_ready;

  logic       w_next_pc;
  logic       w_ir_write;
  logic       w_reg_w;
  logic       w_mem_w;
  logic       w_branch;
  logic       w_alu_op;
  logic       w_adr_src;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic [1:0] w_res_src;
  logic [1:0] w_alu_control;
  logic [1:0] w_flag_w_raw;
  logic       w_rd_pc;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign w_ready = bus.mem_ready;
`else
  assign w_ready = 1'b1;
`endif

  // r_run holds the FSM in a strobe-free FETCH until the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_state <= r_run ? w_next_state : S_FETCH;
    end
  end

  // Next-state and raw per-state controls.
  always_comb begin
    w_next_state = S_FETCH;
    w_next_pc    = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_w      = 1'b0;
    w_mem_w      = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 1'b0;
    w_adr_src    = 1'b0;
    w_src_a      = SRCA_RN;
    w_src_b      = SRCB_RM;
    w_res_src    = RES_ALUOUT;
    case (r_state)
      S_FETCH: begin
        w_src_a   = SRCA_PC;
        w_src_b   = SRCB_FOUR;
        w_res_src = RES_ALURESULT;
        if (w_ready) begin
          w_ir_write   = 1'b1;
          w_next_pc    = 1'b1;
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        w_src_a   = SRCA_PC;
        w_src_b   = SRCB_FOUR;
        w_res_src = RES_ALURESULT;
        case (bus.Op)
          OP_DP:   w_next_state = bus.Funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  w_next_state = S_MEMADR;
          OP_BR:   w_next_state = S_BRANCH;
          default: w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_src_a      = SRCA_RN;
        w_src_b      = SRCB_IMM;
        w_next_state = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adr_src    = 1'b1;
        w_next_state = w_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWR: begin
        w_adr_src = 1'b1;
        if (w_ready) begin
          w_mem_w      = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_MEMWR;
        end
      end
      S_MEMWB: begin
        w_res_src    = RES_DATA;
        w_reg_w      = 1'b1;
        w_next_state = S_FETCH;
      end
      S_EXECR: begin
        w_src_a      = SRCA_RN;
        w_src_b      = SRCB_RM;
        w_alu_op     = 1'b1;
        w_next_state = is_cmp(bus.Funct[4:1]) ? S_FETCH : S_ALUWB;
      end
      S_EXECI: begin
        w_src_a      = SRCA_RN;
        w_src_b      = SRCB_IMM;
        w_alu_op     = 1'b1;
        w_next_state = is_cmp(bus.Funct[4:1]) ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        w_res_src    = RES_ALUOUT;
        w_reg_w      = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        w_src_a      = SRCA_ALUOUT;
        w_src_b      = SRCB_IMM;
        w_res_src    = RES_ALURESULT;
        w_branch     = 1'b1;
        w_next_state = S_FETCH;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  alu_dec u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct       (bus.Funct[4:0]),
    .o_alu_control (w_alu_control),
    .o_flag_w_raw  (w_flag_w_raw)
  );

  assign w_rd_pc = (bus.Rd == 4'd15);

  // Architectural strobes are condition-gated and silenced until r_run is set.
  assign bus.PCWrite    = r_run & (w_next_pc | (w_branch & bus.CondEx) |
                                   (w_reg_w & bus.CondEx & w_rd_pc));
  assign bus.IRWrite    = r_run & w_ir_write;
  assign bus.RegWrite   = r_run & w_reg_w & bus.CondEx;
  assign bus.MemWrite   = r_run & w_mem_w & bus.CondEx;
  assign bus.FlagW      = (r_run & bus.CondEx) ? w_flag_w_raw : 2'b00;
  assign bus.AdrSrc     = w_adr_src;
  assign bus.ALUSrcA    = w_src_a;
  assign bus.ALUSrcB    = w_src_b;
  assign bus.ResultSrc  = w_res_src;
  assign bus.ALUControl = w_alu_control;
  assign bus.state      = r_state;

endmodule
